// File: rtl/ahb_burst_master_pkg.sv
// Shared AHB definitions and state encoding for the burst master engine.
//   - htrans / hburst / hresp encodings and the fixed word hsize
//   - bus widths and the state enum of ahb_burst_master
package ahb_burst_master_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 5;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_XFER  = 2'b10,
        ST_DRAIN = 2'b11
    } state_e;

endpackage

// File: rtl/ahb_addr_gen.sv
// Next beat address for a word-sized AHB burst.
//   addr        : current address phase address
//   burst       : burst type of the original command (wrap window source)
//   next_addr_c : address of the following beat
//   cross_1k_c  : incrementing next address lands in a new 1 KB page
module ahb_addr_gen
    import ahb_burst_master_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        burst,
    output logic [ADDR_W-1:0] next_addr_c,
    output logic              cross_1k_c
);

    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] wrap_mask;

    // Wrap bursts keep the upper bits and wrap the low bits inside an n*4-byte window
    always_comb begin
        incr      = addr + ADDR_W'(4);
        wrap_mask = '0;
        case (burst)
            HBURST_WRAP4:  wrap_mask = ADDR_W'(32'h0000_000F);
            HBURST_WRAP8:  wrap_mask = ADDR_W'(32'h0000_001F);
            HBURST_WRAP16: wrap_mask = ADDR_W'(32'h0000_003F);
            default:       wrap_mask = '0;
        endcase
        if (wrap_mask != '0) begin
            next_addr_c = (addr & ~wrap_mask) | (incr & wrap_mask);
            cross_1k_c  = 1'b0;
        end else begin
            next_addr_c = incr;
            cross_1k_c  = (incr[ADDR_W-1:10] != addr[ADDR_W-1:10]);
        end
    end

endmodule

// File: rtl/ahb_burst_master.sv
// Requester-side AHB burst master: one command at a time, bus request,
// NONSEQ/SEQ address phases, data movement, grant loss, ERROR, RETRY, SPLIT.
//   cmd_*           : command handshake (cmd_ready high only when idle)
//   wr_data/wr_pop  : upstream write FIFO head and advance pulse
//   rd_data/rd_valid: read beat output
//   done/err        : end-of-command pulse, err marks ERROR termination
//   hbusreq/hgrant  : arbiter handshake
//   h*              : AHB master drive and slave response
module ahb_burst_master
    import ahb_burst_master_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [2:0]        cmd_burst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              err,
    output logic              hbusreq,
    input  logic              hgrant,
    input  logic              hready,
    input  logic [1:0]        hresp,
    input  logic [DATA_W-1:0] hrdata,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hburst,
    output logic [2:0]        hsize,
    output logic [DATA_W-1:0] hwdata
);

    state_e            state, state_n;
    logic [LEN_W-1:0]  remaining, remaining_n;   // address phases still to issue
    logic              pending, pending_n;       // data phase outstanding
    logic [ADDR_W-1:0] dp_addr, dp_addr_n;       // address of the outstanding data phase
    logic [LEN_W-1:0]  dp_rem, dp_rem_n;         // remaining count after that beat was issued
    logic [2:0]        burst_q, burst_q_n;       // original burst, drives the address pattern
    logic [ADDR_W-1:0] haddr_n;
    logic [1:0]        htrans_n;
    logic              hwrite_n;
    logic [2:0]        hburst_n;
    logic              hbusreq_n;
    logic [DATA_W-1:0] rd_data_n;
    logic              done_n, err_n, rd_valid_n, wr_pop_n, cmd_ready_n;

    logic [ADDR_W-1:0] next_addr_c;
    logic              cross_1k_c;
    logic              dp_err1_c, dp_err2_c, dp_rty1_c;

    assign hsize  = HSIZE_WORD;
    assign hwdata = wr_data;

    // Beat count of a command; INCR length 0 means 1, capped at MAX_BEATS
    function automatic logic [LEN_W-1:0] beats_of(input logic [2:0] b, input logic [LEN_W-1:0] len);
        case (b)
            HBURST_SINGLE:               beats_of = LEN_W'(1);
            HBURST_WRAP4,  HBURST_INCR4:  beats_of = LEN_W'(4);
            HBURST_WRAP8,  HBURST_INCR8:  beats_of = LEN_W'(8);
            HBURST_WRAP16, HBURST_INCR16: beats_of = LEN_W'(16);
            default: begin
                if (len == '0)                    beats_of = LEN_W'(1);
                else if (32'(len) > MAX_BEATS)    beats_of = LEN_W'(MAX_BEATS);
                else                              beats_of = len;
            end
        endcase
    endfunction

    ahb_addr_gen u_addr_gen (
        .addr        (haddr),
        .burst       (burst_q),
        .next_addr_c (next_addr_c),
        .cross_1k_c  (cross_1k_c)
    );

    // First and second cycles of the two-cycle slave responses
    assign dp_err1_c = pending && !hready && (hresp == HRESP_ERROR);
    assign dp_err2_c = pending &&  hready && (hresp == HRESP_ERROR);
    assign dp_rty1_c = pending && !hready && ((hresp == HRESP_RETRY) || (hresp == HRESP_SPLIT));

    // State and output registers
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            pending   <= 1'b0;
            dp_addr   <= '0;
            dp_rem    <= '0;
            burst_q   <= HBURST_SINGLE;
            haddr     <= '0;
            htrans    <= HTRANS_IDLE;
            hwrite    <= 1'b0;
            hburst    <= HBURST_SINGLE;
            hbusreq   <= 1'b0;
            rd_data   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            rd_valid  <= 1'b0;
            wr_pop    <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            pending   <= pending_n;
            dp_addr   <= dp_addr_n;
            dp_rem    <= dp_rem_n;
            burst_q   <= burst_q_n;
            haddr     <= haddr_n;
            htrans    <= htrans_n;
            hwrite    <= hwrite_n;
            hburst    <= hburst_n;
            hbusreq   <= hbusreq_n;
            rd_data   <= rd_data_n;
            done      <= done_n;
            err       <= err_n;
            rd_valid  <= rd_valid_n;
            wr_pop    <= wr_pop_n;
            cmd_ready <= cmd_ready_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        pending_n   = pending;
        dp_addr_n   = dp_addr;
        dp_rem_n    = dp_rem;
        burst_q_n   = burst_q;
        haddr_n     = haddr;
        htrans_n    = htrans;
        hwrite_n    = hwrite;
        hburst_n    = hburst;
        hbusreq_n   = hbusreq;
        rd_data_n   = rd_data;
        done_n      = 1'b0;
        err_n       = 1'b0;
        rd_valid_n  = 1'b0;
        wr_pop_n    = 1'b0;

        if (state == ST_IDLE) begin
            // In REQ, haddr holds the address the next NONSEQ will use
            if (cmd_valid && cmd_ready) begin
                haddr_n     = cmd_addr;
                hwrite_n    = cmd_write;
                hburst_n    = cmd_burst;
                burst_q_n   = cmd_burst;
                remaining_n = beats_of(cmd_burst, cmd_len);
                hbusreq_n   = 1'b1;
                pending_n   = 1'b0;
                state_n     = ST_REQ;
            end
        end else if (dp_err1_c) begin
            htrans_n = HTRANS_IDLE;
        end else if (dp_err2_c) begin
            htrans_n  = HTRANS_IDLE;
            pending_n = 1'b0;
            hbusreq_n = 1'b0;
            done_n    = 1'b1;
            err_n     = 1'b1;
            state_n   = ST_IDLE;
        end else if (dp_rty1_c) begin
            // Rewind to the refused beat; it restarts as an undefined-length burst
            htrans_n    = HTRANS_IDLE;
            haddr_n     = dp_addr;
            remaining_n = dp_rem + LEN_W'(1);
            hburst_n    = HBURST_INCR;
            pending_n   = 1'b0;
            hbusreq_n   = 1'b1;
            state_n     = ST_REQ;
        end else if (hready) begin
            if (pending) begin
                pending_n = 1'b0;
                if (hwrite) begin
                    wr_pop_n = 1'b1;
                end else begin
                    rd_valid_n = 1'b1;
                    rd_data_n  = hrdata;
                end
            end
            case (state)
                ST_REQ: begin
                    if (hgrant) begin
                        htrans_n    = HTRANS_NONSEQ;
                        remaining_n = remaining - LEN_W'(1);
                        state_n     = ST_XFER;
                        if ((remaining == LEN_W'(1)) && (hburst != HBURST_INCR)) begin
                            hbusreq_n = 1'b0;
                        end
                    end
                end
                ST_XFER: begin
                    // The driven address phase is accepted on this edge
                    pending_n = 1'b1;
                    dp_addr_n = haddr;
                    dp_rem_n  = remaining;
                    if (remaining == '0) begin
                        htrans_n  = HTRANS_IDLE;
                        hbusreq_n = 1'b0;
                        state_n   = ST_DRAIN;
                    end else if (!hgrant) begin
                        htrans_n = HTRANS_IDLE;
                        haddr_n  = next_addr_c;
                        hburst_n = HBURST_INCR;
                        state_n  = ST_REQ;
                    end else begin
                        haddr_n     = next_addr_c;
                        remaining_n = remaining - LEN_W'(1);
                        if (cross_1k_c) begin
                            htrans_n = HTRANS_NONSEQ;
                            hburst_n = HBURST_INCR;
                        end else begin
                            htrans_n = HTRANS_SEQ;
                        end
                        if ((remaining == LEN_W'(1)) && (hburst_n != HBURST_INCR)) begin
                            hbusreq_n = 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    hbusreq_n = 1'b0;
                    done_n    = 1'b1;
                    state_n   = ST_IDLE;
                end
                default: ;
            endcase
        end

        // The done cycle never accepts a new command
        cmd_ready_n = (state_n == ST_IDLE) && !done_n;
    end

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master with a simple zero-wait slave model.
module tb_ahb_burst_master;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [2:0]  cmd_burst;
    logic [4:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_pop;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;
    logic        hbusreq;
    logic        hgrant;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic [31:0] hwdata;

    int errors = 0;
    int checks = 0;

    // Monitor state (written only by the monitor process)
    logic [31:0] a_addr[$];
    logic [1:0]  a_trans[$];
    logic [2:0]  a_burst[$];
    logic [31:0] rd_q[$];
    int          wr_pop_cnt = 0;
    int          done_cnt = 0;
    logic        last_err = 1'b0;

    logic [31:0] sl_addr = 32'h0;
    int          wr_idx = 0;
    logic [31:0] exp_tab[8];

    ahb_burst_master dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_write (cmd_write),
        .cmd_burst (cmd_burst),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_pop    (wr_pop),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .done      (done),
        .err       (err),
        .hbusreq   (hbusreq),
        .hgrant    (hgrant),
        .hready    (hready),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hburst    (hburst),
        .hsize     (hsize),
        .hwdata    (hwdata)
    );

    always #5 hclk = ~hclk;

    // Slave: read data identifies the address of the data phase
    always @(posedge hclk) begin
        if (hready && htrans[1]) sl_addr <= haddr;
        if (wr_pop) wr_idx <= wr_idx + 1;
    end
    assign hrdata  = {16'hD00D, sl_addr[15:0]};
    assign wr_data = 32'hCAFE_0000 + 32'(wr_idx);

    // Monitor at the falling edge: accepted address phases and pulses
    always @(negedge hclk) begin
        if (!hreset) begin
            if (hready && htrans[1]) begin
                a_addr.push_back(haddr);
                a_trans.push_back(htrans);
                a_burst.push_back(hburst);
            end
            if (wr_pop) wr_pop_cnt++;
            if (rd_valid) rd_q.push_back(rd_data);
            if (done) begin
                done_cnt++;
                last_err = err;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] b, input logic [4:0] l);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_write = w;
        cmd_burst = b;
        cmd_len   = l;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int n = 0;
        while (done_cnt == base && n < 300) begin
            cyc();
            n++;
        end
        chk("done_seen", 32'(done_cnt - base), 32'd1);
    endtask

    task automatic chk_phase(input string tag, input int idx, input logic [31:0] a,
                             input logic [1:0] t, input logic [2:0] b);
        if (idx < a_addr.size()) begin
            chk({tag, "_addr"}, a_addr[idx], a);
            chk({tag, "_trans"}, 32'(a_trans[idx]), 32'(t));
            chk({tag, "_burst"}, 32'(a_burst[idx]), 32'(b));
        end else begin
            chk({tag, "_missing"}, 32'hxxxx_xxxx, a);
        end
    endtask

    initial begin
        int ab, rb, wb, db;
        hreset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_write = 1'b0;
        cmd_burst = 3'b000;
        cmd_len   = 5'd0;
        hgrant    = 1'b1;
        hready    = 1'b1;
        hresp     = 2'b00;

        // Reset values
        cyc();
        cyc();
        chk("rst_hbusreq", 32'(hbusreq), 32'd0);
        chk("rst_htrans", 32'(htrans), 32'd0);
        chk("rst_haddr", haddr, 32'h0);
        chk("rst_hburst", 32'(hburst), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_pop", 32'(wr_pop), 32'd0);
        chk("rst_hsize", 32'(hsize), 32'd2);
        hreset = 1'b0;
        cyc();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Write INCR4 @0x100, cycle-exact
        wb = wr_pop_cnt;
        issue(32'h100, 1'b1, 3'b011, 5'd0);
        chk("t1_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("t1_busreq", 32'(hbusreq), 32'd1);
        chk("t1_req_idle", 32'(htrans), 32'd0);
        chk("t1_hwdata", hwdata, 32'hCAFE_0000);
        cyc();
        chk("t1_ns_trans", 32'(htrans), 32'd2);
        chk("t1_ns_addr", haddr, 32'h100);
        chk("t1_ns_burst", 32'(hburst), 32'd3);
        chk("t1_ns_write", 32'(hwrite), 32'd1);
        cyc();
        chk("t1_s1_trans", 32'(htrans), 32'd3);
        chk("t1_s1_addr", haddr, 32'h104);
        cyc();
        chk("t1_s2_addr", haddr, 32'h108);
        chk("t1_pop1", 32'(wr_pop), 32'd1);
        cyc();
        chk("t1_s3_addr", haddr, 32'h10C);
        chk("t1_s3_trans", 32'(htrans), 32'd3);
        chk("t1_busreq_drop", 32'(hbusreq), 32'd0);
        cyc();
        chk("t1_idle", 32'(htrans), 32'd0);
        chk("t1_no_done_yet", 32'(done), 32'd0);
        cyc();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_last_pop", 32'(wr_pop), 32'd1);
        chk("t1_done_not_ready", 32'(cmd_ready), 32'd0);
        // Next command presented during the done cycle must wait one cycle
        ab = a_addr.size();
        rb = rd_q.size();
        cmd_valid = 1'b1;
        cmd_addr  = 32'h118;
        cmd_write = 1'b0;
        cmd_burst = 3'b100;
        cmd_len   = 5'd0;
        cyc();
        chk("t1_wr_pops", 32'(wr_pop_cnt - wb), 32'd4);
        chk("t2_not_accepted", 32'(hbusreq), 32'd0);
        chk("t2_ready_after_done", 32'(cmd_ready), 32'd1);
        db = done_cnt;
        cyc();
        cmd_valid = 1'b0;
        chk("t2_accepted", 32'(hbusreq), 32'd1);

        // Read WRAP8 @0x118
        wait_done(db);
        exp_tab = '{32'h118, 32'h11C, 32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114};
        chk("t2_addr_count", 32'(a_addr.size() - ab), 32'd8);
        chk("t2_rd_count", 32'(rd_q.size() - rb), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk_phase("t2", ab + i, exp_tab[i], (i == 0) ? 2'b10 : 2'b11, 3'b100);
            if (rb + i < rd_q.size()) chk("t2_rdata", rd_q[rb + i], {16'hD00D, exp_tab[i][15:0]});
        end

        // INCR len 6 @0x200 with grant loss after the second address
        ab = a_addr.size();
        wb = wr_pop_cnt;
        db = done_cnt;
        issue(32'h200, 1'b1, 3'b001, 5'd6);
        cyc();
        cyc();
        hgrant = 1'b0;
        cyc();
        chk("t3_lost_idle", 32'(htrans), 32'd0);
        chk("t3_rereq", 32'(hbusreq), 32'd1);
        cyc();
        chk("t3_wait_idle", 32'(htrans), 32'd0);
        hgrant = 1'b1;
        cyc();
        chk("t3_resume_trans", 32'(htrans), 32'd2);
        chk("t3_resume_addr", haddr, 32'h208);
        chk("t3_resume_burst", 32'(hburst), 32'd1);
        wait_done(db);
        chk("t3_addr_count", 32'(a_addr.size() - ab), 32'd6);
        chk("t3_wr_pops", 32'(wr_pop_cnt - wb), 32'd6);
        chk("t3_err", 32'(last_err), 32'd0);
        chk_phase("t3_b1", ab + 1, 32'h204, 2'b11, 3'b001);
        chk_phase("t3_b2", ab + 2, 32'h208, 2'b10, 3'b001);
        chk_phase("t3_b5", ab + 5, 32'h214, 2'b11, 3'b001);

        // INCR4 write, ERROR on the second beat
        ab = a_addr.size();
        wb = wr_pop_cnt;
        db = done_cnt;
        issue(32'h300, 1'b1, 3'b011, 5'd0);
        cyc();
        cyc();
        cyc();
        hready = 1'b0;
        hresp  = 2'b01;
        cyc();
        chk("t4_err1_idle", 32'(htrans), 32'd0);
        chk("t4_err1_no_done", 32'(done), 32'd0);
        hready = 1'b1;
        cyc();
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_busreq", 32'(hbusreq), 32'd0);
        hresp = 2'b00;
        cyc();
        chk("t4_ready", 32'(cmd_ready), 32'd1);
        chk("t4_wr_pops", 32'(wr_pop_cnt - wb), 32'd1);
        chk("t4_addr_count", 32'(a_addr.size() - ab), 32'd2);
        chk("t4_done_count", 32'(done_cnt - db), 32'd1);

        // SINGLE write @0x40 answered RETRY once
        ab = a_addr.size();
        wb = wr_pop_cnt;
        db = done_cnt;
        issue(32'h40, 1'b1, 3'b000, 5'd0);
        cyc();
        chk("t5_single_busreq", 32'(hbusreq), 32'd0);
        cyc();
        hready = 1'b0;
        hresp  = 2'b10;
        cyc();
        chk("t5_rty_idle", 32'(htrans), 32'd0);
        chk("t5_rty_rereq", 32'(hbusreq), 32'd1);
        chk("t5_rty_no_pop", 32'(wr_pop_cnt - wb), 32'd0);
        hready = 1'b1;
        cyc();
        chk("t5_reissue_trans", 32'(htrans), 32'd2);
        chk("t5_reissue_addr", haddr, 32'h40);
        chk("t5_reissue_burst", 32'(hburst), 32'd1);
        hresp = 2'b00;
        wait_done(db);
        chk("t5_wr_pops", 32'(wr_pop_cnt - wb), 32'd1);
        chk("t5_err", 32'(last_err), 32'd0);
        chk("t5_addr_count", 32'(a_addr.size() - ab), 32'd2);

        // INCR len 4 @0x3F8 crossing 1 KB, then reset mid-burst
        db = done_cnt;
        issue(32'h3F8, 1'b0, 3'b001, 5'd4);
        cyc();
        chk("t6_ns_addr", haddr, 32'h3F8);
        cyc();
        chk("t6_seq_trans", 32'(htrans), 32'd3);
        chk("t6_seq_addr", haddr, 32'h3FC);
        cyc();
        chk("t6_cross_trans", 32'(htrans), 32'd2);
        chk("t6_cross_addr", haddr, 32'h400);
        hreset = 1'b1;
        cyc();
        chk("t6_rst_htrans", 32'(htrans), 32'd0);
        chk("t6_rst_busreq", 32'(hbusreq), 32'd0);
        chk("t6_rst_ready", 32'(cmd_ready), 32'd1);
        chk("t6_rst_haddr", haddr, 32'h0);
        hreset = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("t6_no_done", 32'(done_cnt - db), 32'd0);
        chk("t6_idle_busreq", 32'(hbusreq), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
